// File: rtl/issue_queue_gen.sv
// In-order issue queue between decode and the reservation stations.
// Circular buffer of DEPTH entries (any depth >= 2, not necessarily a power
// of two) with an occupancy counter, a programmable almost-full flag and a
// single-cycle flush. There is no fall-through: a pushed entry appears on
// data_o one cycle later. While full, a push is refused even if a pop
// happens in the same cycle.
module issue_queue_gen #(
  parameter int unsigned DATA_W   = 96,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AFULL_TH = DEPTH - 1,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              afull_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("issue_queue_gen: DEPTH must be at least 2");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
      $error("issue_queue_gen: AFULL_TH must lie in 1..DEPTH");
    end
  endgenerate

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Flags come straight from the registered count, so ready_o/valid_o have
  // no path from valid_i or ready_i.
  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CNT_W'(DEPTH));
    afull_o = (count_q >= CNT_W'(AFULL_TH));
    ready_o = ~full_o;
    valid_o = ~empty_o;
    count_o = count_q;
    data_o  = valid_o ? mem_q[head_q] : '0;
  end

  // Handshakes in a flush or reset cycle are dropped entirely.
  always_comb begin
    push    = valid_i & ready_o & ~flush_i & ~rst_i;
    pop     = valid_o & ready_i & ~flush_i & ~rst_i;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      tail_d = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d = ptr_inc(head_q);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; reset and flush both empty the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; only accepted pushes write it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[tail_q] <= data_i;
    end
  end

endmodule

// File: tb/tb_issue_queue_gen.sv
// Directed bench for issue_queue_gen at DEPTH=6, AFULL_TH=4, DATA_W=16.
module tb_issue_queue_gen;

  localparam int DW = 16;
  localparam int DP = 6;
  localparam int AT = 4;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst, flush, vin, rdy_in;
  logic [DW-1:0] din;
  logic          rdy_out, vout, empty, full, afull;
  logic [DW-1:0] dout;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  issue_queue_gen #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(AT)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .valid_i (vin),
    .ready_o (rdy_out),
    .data_i  (din),
    .valid_o (vout),
    .ready_i (rdy_in),
    .data_o  (dout),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full),
    .afull_o (afull)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;
    logic [2:0]    ecount;
    logic [DW-1:0] edata;
  } vec_t;

  vec_t vecs [17];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Check every output against the state implied by an expected occupancy.
  task automatic check_all(input string tag, input int ecount, input logic [DW-1:0] edata);
    cmp({tag, " count"}, 32'(count), 32'(ecount));
    cmp({tag, " empty"}, 32'(empty), 32'(ecount == 0));
    cmp({tag, " full"},  32'(full),  32'(ecount == DP));
    cmp({tag, " afull"}, 32'(afull), 32'(ecount >= AT));
    cmp({tag, " valid"}, 32'(vout),  32'(ecount != 0));
    cmp({tag, " ready"}, 32'(rdy_out), 32'(ecount != DP));
    cmp({tag, " data"},  32'(dout),  32'(edata));
  endtask

  // Drive one cycle of inputs, then land #1 after the rising edge.
  task automatic cyc(input logic r, input logic f, input logic v,
                     input logic [DW-1:0] d, input logic rd);
    rst = r; flush = f; vin = v; din = d; rdy_in = rd;
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; vin = 1'b0; din = '0; rdy_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] model [$];
    logic [DW-1:0] nv;

    // {valid, data, ready, expected count, expected data_o} before each edge
    vecs[0]  = '{1'b1, 16'h0001, 1'b0, 3'd0, 16'h0000};
    vecs[1]  = '{1'b1, 16'h0002, 1'b0, 3'd1, 16'h0001};
    vecs[2]  = '{1'b1, 16'h0003, 1'b0, 3'd2, 16'h0001};
    vecs[3]  = '{1'b1, 16'h0004, 1'b0, 3'd3, 16'h0001};
    vecs[4]  = '{1'b1, 16'h0005, 1'b0, 3'd4, 16'h0001};
    vecs[5]  = '{1'b1, 16'h0006, 1'b0, 3'd5, 16'h0001};
    vecs[6]  = '{1'b1, 16'h0007, 1'b0, 3'd6, 16'h0001};
    vecs[7]  = '{1'b1, 16'h0008, 1'b1, 3'd6, 16'h0001};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 3'd5, 16'h0002};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 3'd4, 16'h0003};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 3'd3, 16'h0004};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 3'd2, 16'h0005};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 3'd1, 16'h0006};
    vecs[13] = '{1'b1, 16'h00A5, 1'b0, 3'd0, 16'h0000};
    vecs[14] = '{1'b0, 16'h0000, 1'b0, 3'd1, 16'h00A5};
    vecs[15] = '{1'b0, 16'h0000, 1'b1, 3'd1, 16'h00A5};
    vecs[16] = '{1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000};

    rst = 1'b1; flush = 1'b0; vin = 1'b0; din = '0; rdy_in = 1'b0;
    @(posedge clk);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check_all("reset", 0, '0);

    // Fill, refused 7th push, no full-bypass, drain, then push into empty.
    for (int i = 0; i < 17; i++) begin
      check_all($sformatf("vec%0d", i), int'(vecs[i].ecount), vecs[i].edata);
      cyc(1'b0, 1'b0, vecs[i].valid, vecs[i].data, vecs[i].ready);
    end

    // Wrap-around: hold count at 3 through 20 push+pop cycles.
    for (int i = 0; i < 3; i++) begin
      nv = DW'(16'h0010 + i);
      cyc(1'b0, 1'b0, 1'b1, nv, 1'b0);
      model.push_back(nv);
    end
    for (int i = 0; i < 20; i++) begin
      nv = DW'(16'h0100 + i);
      cmp($sformatf("wrap%0d count", i), 32'(count), 32'd3);
      cmp($sformatf("wrap%0d data", i), 32'(dout), 32'(model[0]));
      cyc(1'b0, 1'b0, 1'b1, nv, 1'b1);
      void'(model.pop_front());
      model.push_back(nv);
    end
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("drain%0d data", i), 32'(dout), 32'(model[0]));
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
      void'(model.pop_front());
    end
    check_all("drained", 0, '0);

    // Flush while full with a push and pop both requested.
    for (int i = 0; i < DP; i++) begin
      cyc(1'b0, 1'b0, 1'b1, DW'(16'h0021 + i), 1'b0);
    end
    check_all("prefull", DP, 16'h0021);
    cyc(1'b0, 1'b1, 1'b1, 16'h00EE, 1'b1);
    check_all("flushed", 0, '0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0055, 1'b0);
    check_all("postflush", 1, 16'h0055);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check_all("postflush pop", 0, '0);

    // One-cycle reset at count 5, then the next push comes out first.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, DW'(16'h0031 + i), 1'b0);
    end
    check_all("prereset", 5, 16'h0031);
    cyc(1'b1, 1'b0, 1'b1, 16'h0099, 1'b1);
    check_all("midreset", 0, '0);
    cyc(1'b0, 1'b0, 1'b1, 16'h003C, 1'b0);
    check_all("postreset", 1, 16'h003C);
    cyc(1'b0, 1'b0, 1'b1, 16'h003D, 1'b1);
    check_all("postreset stream", 1, 16'h003D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_queue_gen.md
# issue_queue_gen

Parametrised in-order issue queue sitting between decode and the reservation stations of the execution pipeline. It generalises the fixed 8-entry issue queue to any depth, including non-power-of-2 depths, and any entry width. It also adds an occupancy count, a programmable almost-full flag for front-end throttling, and a single-cycle flush for mispredict recovery.

## Interface
- DATA_W, default 96: entry width in bits.
- DEPTH, default 8: number of entries; any integer ≥ 2, power of 2 not required.
- AFULL_TH, default DEPTH-1: occupancy at or above which afull_o asserts; legal range 1..DEPTH.
- CNT_W, default $clog2(DEPTH+1): width of count_o; derived, not to be overridden.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  discard all entries.
- valid_i  in  1  producer has an entry on data_i.
- ready_o  out  1  queue accepts an entry this cycle.
- data_i  in  DATA_W  entry to enqueue.
- valid_o  out  1  data_o holds the oldest entry.
- ready_i  in  1  consumer takes data_o this cycle.
- data_o  out  DATA_W  oldest entry.
- count_o  out  CNT_W  current occupancy, 0..DEPTH.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == DEPTH.
- afull_o  out  1  count_o ≥ AFULL_TH.

## Operation
- Storage is a circular buffer of DEPTH entries with head (read) and tail (write) pointers, each $clog2(DEPTH) bits, plus an occupancy counter.
- Pointer increment wraps explicitly: value DEPTH-1 goes to 0. Binary overflow must not be relied on.
- Push = valid_i & ready_o. It writes data_i at tail and advances tail.
- Pop = valid_o & ready_i. It advances head.
- ready_o = !full_o. A push is never accepted while full, even if a pop happens in the same cycle (no full-bypass).
- valid_o = !empty_o. data_o = storage[head] when valid_o, else all-zero.
- No fall-through: an entry pushed into an empty queue is visible on data_o one cycle later.
- Count update per cycle: push only +1; pop only −1; push and pop together: unchanged, both pointers advance; neither: hold.
- Flush: head, tail and count go to 0 at the next edge. Any push or pop in the flush cycle is ignored, and its data is not stored.
- Reset has the same effect as flush and takes precedence over it. Storage contents are not reset.
- Flags are pure functions of the registered count; there are no extra state bits.
- Elaboration checks: error if DEPTH < 2 or AFULL_TH is outside 1..DEPTH.

## Timing
- Reset values: count_o=0, empty_o=1, full_o=0, afull_o=0, valid_o=0, ready_o=1, data_o=0.
- Push-to-output latency is 1 cycle. Pop takes effect at the edge, and the next entry is on data_o in the following cycle.
- Throughput is one push and one pop per cycle while neither empty nor full.
- ready_o and valid_o depend only on registered state. There is no combinational path from valid_i or ready_i to either.
- data_o has a combinational read-mux path from the head register and storage only.
- Flush or reset in the middle of a streaming sequence: the next cycle shows the reset values. A push in the following cycle is accepted normally.
- Simultaneous push and pop at count 0 is impossible because valid_o=0. At count DEPTH it is impossible because ready_o=0.

## Test plan
- DEPTH=6, AFULL_TH=4, push 1..6 with ready_i=0: count_o steps 1..6, afull_o rises when count_o=4, full_o=1 and ready_o=0 at 6. A 7th push is not accepted.
- Same configuration, then pop all with ready_i=1: data_o reads 1,2,…,6 in order, empty_o=1 after the 6th pop, data_o=0.
- Wrap-around with DEPTH=6: 20 cycles of simultaneous push and pop starting at count=3. count_o stays 3, output order is preserved across tail going 5→0 and head going 5→0, and no entry is lost or duplicated.
- Push one value 0xA5 into an empty queue: valid_o=0 in the push cycle and valid_o=1 with data_o=0xA5 in the next cycle.
- Full queue with flush_i=1 while valid_i=1 and ready_i=1: next cycle count_o=0, empty_o=1, ready_o=1, and the flushed-cycle push does not appear later.
- Assert rst_i for 1 cycle with count=5: all outputs match the reset values next cycle. A subsequent push of 0x3C is output first.
